// File: rtl/regfile_posted_if.sv
// Bus bundle for regfile_posted: one write port, two read ports, taps and write-back status.
// The master drives requests; the slave (the register file) returns read data and status.
interface regfile_posted_if #(
    parameter int N     = 8,
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    // we is a one-cycle write strobe with no back-pressure: each cycle with we=1 is one write.
    logic                 we;
    logic [AW-1:0]        waddr;
    logic [N-1:0]         wdata;
    logic [AW-1:0]        raddr1;
    logic [AW-1:0]        raddr2;
    logic signed [N-1:0]  rdata1;
    logic signed [N-1:0]  rdata2;
    logic signed [N-1:0]  tap_a;
    logic signed [N-1:0]  tap_b;
    logic                 wb_pending;

    modport master (
        output we, waddr, wdata, raddr1, raddr2,
        input  rdata1, rdata2, tap_a, tap_b, wb_pending
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2,
        output rdata1, rdata2, tap_a, tap_b, wb_pending
    );
endinterface

// File: rtl/regfile_posted.sv
// picoMIPS register file with a one-entry posted write-back stage and forwarding reads.
// Define REGFILE_WBYPASS_EN to also forward the same-cycle incoming write to the read ports.
module regfile_posted #(
    parameter int N     = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int TAP_A = 2,
    parameter int TAP_B = 4
) (
    input  logic             clk,
    input  logic             reset,
    regfile_posted_if.slave  bus
);

    logic [N-1:0]  regs [DEPTH];
    logic          stage_valid;
    logic [AW-1:0] stage_addr;
    logic [N-1:0]  stage_data;
    logic          wr_ok;
    logic [AW-1:0] raddr [2];
    logic [N-1:0]  rdata [2];

    // Address 0 is hardwired zero; codes at or above DEPTH do not exist.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && (int'(a) < DEPTH);
    endfunction

    assign wr_ok = bus.we && addr_ok(bus.waddr);

    // The reset controller upstream releases reset synchronously to clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_valid <= 1'b0;
            stage_addr  <= '0;
            stage_data  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (stage_valid) begin
                regs[stage_addr] <= stage_data;
            end
            stage_valid <= wr_ok;
            if (wr_ok) begin
                stage_addr <= bus.waddr;
                stage_data <= bus.wdata;
            end
        end
    end

    assign raddr[0] = bus.raddr1;
    assign raddr[1] = bus.raddr2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = '0;
            if (addr_ok(raddr[p])) begin
                if (stage_valid && (stage_addr == raddr[p])) begin
                    rdata[p] = stage_data;
                end else begin
                    rdata[p] = regs[raddr[p]];
                end
`ifdef REGFILE_WBYPASS_EN
                // Incoming write wins over everything, except while reset holds the file at zero.
                if (wr_ok && !reset && (bus.waddr == raddr[p])) begin
                    rdata[p] = bus.wdata;
                end
`endif
            end
        end
    end

    assign bus.rdata1     = rdata[0];
    assign bus.rdata2     = rdata[1];
    assign bus.wb_pending = stage_valid;

    // Taps show committed contents only; an unusable tap index drives constant zero.
    generate
        if (TAP_A > 0 && TAP_A < DEPTH) begin : g_tap_a
            assign bus.tap_a = regs[TAP_A];
        end else begin : g_tap_a_zero
            assign bus.tap_a = '0;
        end
        if (TAP_B > 0 && TAP_B < DEPTH) begin : g_tap_b
            assign bus.tap_b = regs[TAP_B];
        end else begin : g_tap_b_zero
            assign bus.tap_b = '0;
        end
    endgenerate

endmodule
